weight_buf_ctrl: RTL and testbench
==================================

# weight_buf_ctrl

Sequencer for the depthwise weight buffers. It accepts a stream of kernel weights and steers them into NLANE circular weight FIFOs, KSIZE*KSIZE words per lane. It then issues the one-cycle weight-load pulse and drives the FIFO read-enable for KSIZE*KSIZE cycles per output pixel over a programmed number of pixels. It sits between the weight fetch path and the per-lane weight FIFOs feeding the depthwise PE array.

## Interface
- DW, 32, weight word width
- KSIZE, 3, kernel side; KK = KSIZE*KSIZE words per lane (must equal FIFO DEPTH)
- NLANE, 4, number of lanes/FIFOs fed
- PIXW, 16, width of pixel count
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse; begins a job when idle, ignored when busy
- num_pix  in  PIXW  pixels to process; sampled on accepted start
- pe_stall  in  1  PE back-pressure; freezes read sequencing while high
- w_valid  in  1  weight stream valid
- w_data  in  DW  weight word
- w_ready  out  1  weight stream ready
- buf_full  in  NLANE  full flags from the lane FIFOs
- buf_data  out  DW  write data to all FIFOs (equals w_data)
- buf_valid  out  NLANE  one-hot write strobe to the selected lane FIFO
- weight_load  out  1  one-cycle pulse to all FIFOs after fill
- buf_rd  out  1  read enable (o_ready) to all FIFOs
- pe_ena  out  1  buf_rd delayed one cycle; FIFO output data valid
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, FILL, LOAD, RUN, DONE.
- IDLE: w_ready=0, buf_rd=0. start=1 latches num_pix, clears counters, goes to FILL, and sets busy on the next cycle.
- FILL: word counter wcnt (0..KK-1) and lane counter lane (0..NLANE-1).
  - w_ready = ~buf_full[lane].
  - A transfer occurs on w_valid & w_ready. It sets buf_valid[lane]=1 combinationally in the same cycle and increments wcnt.
  - When wcnt wraps from KK-1 to 0, lane increments.
  - The transfer of the last word (lane=NLANE-1, wcnt=KK-1) moves to LOAD.
  - w_valid low or a full lane inserts wait cycles with no strobe.
- LOAD: weight_load=1 for exactly one cycle, then RUN, or DONE if the latched num_pix==0.
- RUN: tap counter tcnt (0..KK-1) and pixel counter pcnt (0..num_pix-1).
  - buf_rd = ~pe_stall. Counters advance only when buf_rd=1.
  - tcnt wraps from KK-1 to 0 and increments pcnt.
  - On tcnt=KK-1 with pcnt=num_pix-1 and buf_rd=1, moves to DONE.
- DONE: done=1 for one cycle; busy drops in the same cycle; next state IDLE.
- pe_ena is a register of buf_rd. It is therefore high exactly once per issued read, including the read in the final RUN cycle.
- buf_data = w_data always. buf_valid is 0 outside FILL.
- Counters are sized clog2(KK), clog2(NLANE) and PIXW bits. No arithmetic overflow is possible: num_pix ≤ 2^PIXW-1.

## Timing
- Reset (rst=1 at a clock edge): state IDLE; all counters 0; w_ready, buf_valid, weight_load, buf_rd, pe_ena, busy and done are 0. This takes effect in any state, including mid-FILL or mid-RUN, with no further strobes issued. Partially filled FIFOs are the upstream's responsibility to reset.
- Minimum job latency with w_valid held high and no stall: 1 (start) + NLANE*KK (FILL) + 1 (LOAD) + num_pix*KK (RUN) + 1 (DONE) cycles.
- weight_load is never coincident with buf_valid or buf_rd.
- The first buf_rd occurs in the cycle after weight_load.
- pe_stall asserted in the same cycle as the last tap holds the state in RUN until pe_stall is released.
- start coincident with done, or arriving during busy, is ignored.

## Test plan
- Basic job, NLANE=4, KSIZE=3, num_pix=2, continuous w_valid, words 0..35 -> lane0 receives 0-8, lane3 receives 27-35; weight_load at cycle 37; buf_rd high for 18 cycles; done at cycle 56.
- Bubbly stream: w_valid toggles every cycle -> 36 strobes total, never two strobes per cycle, correct lane order; FILL lasts 72 cycles.
- Back-pressure: buf_full[1]=1 for 5 cycles while lane=1 -> w_ready=0 and no strobes during those cycles; the job then completes correctly.
- pe_stall pulses: stall 3 cycles at tap 4 of pixel 0 -> buf_rd low 3 cycles; pe_ena count = 9*num_pix; done delayed by 3 cycles.
- num_pix=0 -> FILL and weight_load occur, buf_rd never asserts, done follows LOAD.
- rst mid-RUN at pixel 1 -> next cycle all outputs 0 and state IDLE; a new start runs a complete job correctly.

Source files
------------

// File: rtl/weight_buf_ctrl.sv
// Depthwise weight-buffer sequencer: steers a weight stream into NLANE lane FIFOs,
// pulses weight_load, then issues KSIZE*KSIZE FIFO reads per output pixel.
module weight_buf_ctrl #(
  parameter int DW    = 32,
  parameter int KSIZE = 3,
  parameter int NLANE = 4,
  parameter int PIXW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIXW-1:0]  num_pix,
  input  logic             pe_stall,
  input  logic             w_valid,
  input  logic [DW-1:0]    w_data,
  output logic             w_ready,
  input  logic [NLANE-1:0] buf_full,
  output logic [DW-1:0]    buf_data,
  output logic [NLANE-1:0] buf_valid,
  output logic             weight_load,
  output logic             buf_rd,
  output logic             pe_ena,
  output logic             busy,
  output logic             done
);

  localparam int KK  = KSIZE * KSIZE;
  localparam int WCW = (KK > 1) ? $clog2(KK) : 1;
  localparam int LW  = (NLANE > 1) ? $clog2(NLANE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LOAD, S_RUN, S_DONE} state_t;

  state_t          state, state_next;
  logic [WCW-1:0]  wcnt, tcnt;
  logic [LW-1:0]   lane;
  logic [PIXW-1:0] pcnt, num_pix_q;
  logic            xfer, wlast, tlast, plast, lane_last;

  assign buf_data  = w_data;
  assign wlast     = (wcnt == WCW'(KK - 1));
  assign tlast     = (tcnt == WCW'(KK - 1));
  assign lane_last = (lane == LW'(NLANE - 1));
  assign plast     = (pcnt == num_pix_q - PIXW'(1));

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next  = state;
    w_ready     = 1'b0;
    buf_valid   = '0;
    weight_load = 1'b0;
    buf_rd      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    xfer        = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_FILL;
      S_FILL: begin
        busy    = 1'b1;
        w_ready = ~buf_full[lane];
        xfer    = w_valid & ~buf_full[lane];
        if (xfer) begin
          buf_valid[lane] = 1'b1;
          if (lane_last && wlast) state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        busy        = 1'b1;
        weight_load = 1'b1;
        state_next  = (num_pix_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        buf_rd = ~pe_stall;
        if (!pe_stall && tlast && plast) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      lane      <= '0;
      tcnt      <= '0;
      pcnt      <= '0;
      num_pix_q <= '0;
      pe_ena    <= 1'b0;
    end else begin
      state  <= state_next;
      pe_ena <= buf_rd;
      if (state == S_IDLE && start) begin
        num_pix_q <= num_pix;
        wcnt      <= '0;
        lane      <= '0;
        tcnt      <= '0;
        pcnt      <= '0;
      end
      if (xfer) begin
        if (wlast) begin
          wcnt <= '0;
          lane <= lane_last ? '0 : lane + LW'(1);
        end else begin
          wcnt <= wcnt + WCW'(1);
        end
      end
      if (buf_rd) begin
        if (tlast) begin
          tcnt <= '0;
          pcnt <= pcnt + PIXW'(1);
        end else begin
          tcnt <= tcnt + WCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_buf_ctrl.sv
// Directed self-checking bench for weight_buf_ctrl (DW=32, KSIZE=3, NLANE=4, PIXW=16).
module tb_weight_buf_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, pe_stall, w_valid;
  logic [15:0] num_pix;
  logic [31:0] w_data, buf_data;
  logic [3:0]  buf_full, buf_valid;
  logic        w_ready, weight_load, buf_rd, pe_ena, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int strobes, rd_cnt, pe_cnt, wl_cnt, wl_cyc, done_cyc;

  weight_buf_ctrl #(.DW(32), .KSIZE(3), .NLANE(4), .PIXW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pix(num_pix), .pe_stall(pe_stall),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .buf_full(buf_full),
    .buf_data(buf_data), .buf_valid(buf_valid), .weight_load(weight_load),
    .buf_rd(buf_rd), .pe_ena(pe_ena), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word n of the stream carries value n, so lane n/9 must receive it.
  always @(negedge clk) begin
    if (buf_valid != 4'b0) begin
      check("strobe_lane", 64'(buf_valid), 64'(1) << (strobes / 9));
      check("strobe_data", 64'(buf_data), 64'(strobes));
      strobes++;
    end
    if (buf_rd) rd_cnt++;
    if (pe_ena) pe_cnt++;
    if (weight_load) begin
      wl_cnt++;
      wl_cyc = cyc - t0;
      check("wl_exclusive", {62'b0, buf_valid != 4'b0, buf_rd}, 64'd0);
    end
    if (done) done_cyc = cyc - t0;
  end

  // mode: 0 basic, 1 bubbly stream, 2 lane-1 back-pressure, 3 pe_stall, 4 reset mid-RUN
  task automatic run_job(input int np, input int mode, input int exp_wl, input int exp_done);
    int len;
    strobes = 0; rd_cnt = 0; pe_cnt = 0; wl_cnt = 0; wl_cyc = -1; done_cyc = -1;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b1; num_pix = 16'(np); w_valid = 1'b0; w_data = 32'd0;
    len = (mode == 4) ? 52 : exp_done + 3;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      start    = (k == 20) || (mode == 0 && k == exp_done);
      num_pix  = start ? 16'd5 : 16'(np);
      w_valid  = (mode == 1) ? (k % 2 == 0) : 1'b1;
      buf_full = (mode == 2 && k >= 10 && k <= 14) ? 4'b0010 : 4'b0000;
      pe_stall = (mode == 3 && k >= 42 && k <= 44);
      rst      = (mode == 4 && k == 49);
      w_data   = 32'(strobes);
      #1;
      if (mode == 2 && k >= 10 && k <= 14) begin
        check("bp_w_ready", 64'(w_ready), 64'd0);
        check("bp_strobe", 64'(buf_valid), 64'd0);
      end
      if (mode == 3 && k >= 42 && k <= 44) check("stall_buf_rd", 64'(buf_rd), 64'd0);
      if (k == 30) check("busy_mid_fill", 64'(busy), 64'd1);
      if (mode == 0 && (k == exp_done + 1 || k == exp_done + 2))
        check("start_at_done_ignored", 64'(busy), 64'd0);
      if (mode == 4 && k == 50)
        check("rst_outputs", {55'b0, w_ready, buf_valid, weight_load, buf_rd, pe_ena, busy, done}, 64'd0);
    end
    start = 1'b0; rst = 1'b0; pe_stall = 1'b0; w_valid = 1'b0; buf_full = 4'b0;
    if (mode == 4) begin
      check("rst_reads_stop", 64'(rd_cnt), 64'd12);
      check("rst_no_done", 64'(done_cyc), 64'(-1));
    end else begin
      check("strobe_count", 64'(strobes), 64'd36);
      check("wl_count", 64'(wl_cnt), 64'd1);
      check("wl_cycle", 64'(wl_cyc), 64'(exp_wl));
      check("done_cycle", 64'(done_cyc), 64'(exp_done));
      check("rd_count", 64'(rd_cnt), 64'(np * 9));
      check("pe_ena_count", 64'(pe_cnt), 64'(np * 9));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_pix = 16'd0; pe_stall = 1'b0;
    w_valid = 1'b1; w_data = 32'd0; buf_full = 4'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {55'b0, w_ready, buf_valid, weight_load, buf_rd, pe_ena, busy, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; w_valid = 1'b0;

    run_job(2, 0, 37, 56);
    run_job(2, 1, 73, 92);
    run_job(2, 2, 42, 61);
    run_job(2, 3, 37, 59);
    run_job(0, 0, 37, 38);
    run_job(2, 4, 37, 0);
    run_job(2, 0, 37, 56);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
